// File: rtl/ic_responder_if.sv
// Fetch-side and refill-side signals of the I-cache responder.
// slave = responder view, master = fetch unit plus backing memory view.
interface ic_responder_if #(
  parameter int AW = 64,
  parameter int DW = 32
);
  logic [AW-1:0] ic_read_addr;
  logic          ic_read_en;
  logic          ic_ready;
  logic [DW-1:0] ic_rdata;
  logic          ic_rvalid;
  logic          ic_flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  modport slave (
    input  ic_read_addr, ic_read_en, ic_flush, mem_gnt, mem_rdata, mem_rvalid,
    output ic_ready, ic_rdata, ic_rvalid, mem_req, mem_addr
  );

  modport master (
    output ic_read_addr, ic_read_en, ic_flush, mem_gnt, mem_rdata, mem_rvalid,
    input  ic_ready, ic_rdata, ic_rvalid, mem_req, mem_addr
  );
endinterface

// File: rtl/ic_responder.sv
// Direct-mapped read-only I-cache: hit returns next cycle, miss refills a whole line then responds.
// Backpressure: ic_ready drops for the whole miss; requests seen while not ready are dropped.
module ic_responder #(
  parameter int IC_ADDR_WIDTH  = 64,
  parameter int IC_DATA_WIDTH  = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ic_responder_if.slave  bus
);
  localparam int WW  = $clog2(WORDS_PER_LINE);
  localparam int IW  = $clog2(LINES);
  localparam int OFF = WW + 2;
  localparam int TW  = IC_ADDR_WIDTH - OFF - IW;

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

  state_t                     state_q, state_d;
  logic [LINES-1:0]           valid_q;
  logic [TW-1:0]              tag_q  [LINES];
  logic [IC_DATA_WIDTH-1:0]   data_q [LINES][WORDS_PER_LINE];
  logic [IC_ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [WW-1:0]              cnt_q, cnt_d;
  logic                       flush_pend_q, flush_pend_d;
  logic                       rvalid_q, rvalid_d;
  logic [IC_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [IC_ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic                       fill_we, set_line, clr_all;

  logic [WW-1:0] req_word, lat_word;
  logic [IW-1:0] req_idx, lat_idx;
  logic [TW-1:0] req_tag, lat_tag;
  logic          hit;
  logic          unused_lo;

  assign unused_lo = ^bus.ic_read_addr[1:0];
  assign req_word  = bus.ic_read_addr[OFF-1:2];
  assign req_idx   = bus.ic_read_addr[OFF+IW-1:OFF];
  assign req_tag   = bus.ic_read_addr[IC_ADDR_WIDTH-1:OFF+IW];
  assign lat_word  = addr_q[OFF-1:2];
  assign lat_idx   = addr_q[OFF+IW-1:OFF];
  assign lat_tag   = addr_q[IC_ADDR_WIDTH-1:OFF+IW];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign bus.ic_ready  = (state_q == IDLE);
  assign bus.mem_req   = (state_q == MISS_REQ);
  assign bus.mem_addr  = maddr_q;
  assign bus.ic_rvalid = rvalid_q | (state_q == RESP);
  // The requested word may be the beat written on the previous edge, so read the array directly.
  assign bus.ic_rdata  = (state_q == RESP) ? data_q[lat_idx][lat_word] : rdata_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    maddr_d      = maddr_q;
    fill_we      = 1'b0;
    set_line     = 1'b0;
    clr_all      = 1'b0;
    if (state_q != IDLE && bus.ic_flush) flush_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.ic_read_en) begin
          if (hit) begin
            rvalid_d = 1'b1;
            rdata_d  = data_q[req_idx][req_word];
          end else begin
            addr_d  = bus.ic_read_addr[IC_ADDR_WIDTH-1:2];
            maddr_d = {bus.ic_read_addr[IC_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            state_d = MISS_REQ;
          end
        end
        clr_all = bus.ic_flush;
      end
      MISS_REQ: begin
        if (bus.mem_gnt) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (bus.mem_rvalid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WW'(WORDS_PER_LINE - 1)) begin
            set_line = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        clr_all      = flush_pend_q | bus.ic_flush;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      maddr_q      <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      maddr_q      <= maddr_d;
      if (clr_all)       valid_q          <= '0;
      else if (set_line) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Data and tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (set_line) tag_q[lat_idx]         <= lat_tag;
    if (fill_we)  data_q[lat_idx][cnt_q] <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_ic_responder.sv
// Directed bench for ic_responder: a cache model checks every cycle, literal checks pin each scenario.
module tb_ic_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ic_responder_if #(.AW(64), .DW(32)) bus ();
  ic_responder #(.IC_ADDR_WIDTH(64), .IC_DATA_WIDTH(32), .LINES(16), .WORDS_PER_LINE(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Cache model: 16 lines x 4 words, tag = addr[63:8], index = addr[7:4], word = addr[3:2].
  bit          m_valid [16];
  logic [55:0] m_tag   [16];
  logic [31:0] m_data  [16][4];
  int          m_phase = 0;   // 0 idle, 1 waiting grant, 2 receiving beats, 3 responding
  logic [63:0] m_addr  = '0;
  int          m_beats = 0;
  bit          m_fp    = 0;
  bit          e_rv    = 0;
  logic [31:0] e_dat   = '0;

  int          n_resp = 0;
  int          n_hs   = 0;
  logic [31:0] resp_q [$];
  logic [63:0] last_maddr = '0;

  always @(negedge clk) begin : compare
    logic [63:0] a;
    logic [3:0]  ix;
    if (!rst_n) begin
      chk("rst_ready",    64'(bus.ic_ready),  64'd1);
      chk("rst_rvalid",   64'(bus.ic_rvalid), 64'd0);
      chk("rst_rdata",    64'(bus.ic_rdata),  64'd0);
      chk("rst_mem_req",  64'(bus.mem_req),   64'd0);
      chk("rst_mem_addr", bus.mem_addr,       64'd0);
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_phase = 0;
      m_fp    = 0;
      e_rv    = 0;
    end else begin
      chk("ready",   64'(bus.ic_ready),  64'(m_phase == 0));
      chk("rvalid",  64'(bus.ic_rvalid), 64'(e_rv));
      if (e_rv) chk("rdata", 64'(bus.ic_rdata), 64'(e_dat));
      chk("mem_req", 64'(bus.mem_req), 64'(m_phase == 1));
      if (m_phase == 1) chk("mem_addr", bus.mem_addr, {m_addr[63:4], 4'h0});
      if (bus.ic_rvalid) begin
        n_resp++;
        resp_q.push_back(bus.ic_rdata);
      end
      if (bus.mem_req && bus.mem_gnt) begin
        n_hs++;
        last_maddr = bus.mem_addr;
      end
      e_rv = 0;
      case (m_phase)
        0: begin
          if (bus.ic_read_en) begin
            a  = bus.ic_read_addr;
            ix = a[7:4];
            if (m_valid[ix] && m_tag[ix] == a[63:8]) begin
              e_rv  = 1;
              e_dat = m_data[ix][a[3:2]];
            end else begin
              m_phase = 1;
              m_addr  = a;
            end
          end
          if (bus.ic_flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end
        1: begin
          if (bus.ic_flush) m_fp = 1;
          if (bus.mem_gnt) begin
            m_phase = 2;
            m_beats = 0;
          end
        end
        2: begin
          if (bus.ic_flush) m_fp = 1;
          if (bus.mem_rvalid) begin
            m_data[m_addr[7:4]][m_beats[1:0]] = bus.mem_rdata;
            m_beats++;
            if (m_beats == 4) begin
              m_valid[m_addr[7:4]] = 1;
              m_tag[m_addr[7:4]]   = m_addr[63:8];
              e_rv    = 1;
              e_dat   = m_data[m_addr[7:4]][m_addr[3:2]];
              m_phase = 3;
            end
          end
        end
        default: begin
          if (m_fp || bus.ic_flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
          m_fp    = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] a);
    bus.ic_read_en   = 1'b1;
    bus.ic_read_addr = a;
    tick();
    bus.ic_read_en   = 1'b0;
  endtask

  // Answers one refill: grant after gdly cycles, beats base..base+3, optional gap and flush pulse.
  task automatic serve(input int gdly, input logic [31:0] base, input int gap_after,
                       input int flush_beat, input bit junk);
    int w = 0;
    while (!bus.mem_req && w < 50) begin
      tick();
      w++;
    end
    if (!bus.mem_req) begin
      chk("mem_req_timeout", 64'(bus.mem_req), 64'd1);
      return;
    end
    repeat (gdly) begin
      if (junk) begin
        bus.ic_read_en   = 1'b1;
        bus.ic_read_addr = 64'h500;
      end
      tick();
    end
    bus.ic_read_en = 1'b0;
    bus.mem_gnt    = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(i);
      bus.ic_flush   = (i == flush_beat);
      tick();
      bus.ic_flush   = 1'b0;
      if (i == gap_after) begin
        bus.mem_rvalid = 1'b0;
        tick();
      end
    end
    bus.mem_rvalid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int hs0;
    int r0;
    bus.ic_read_en   = 1'b0;
    bus.ic_read_addr = '0;
    bus.ic_flush     = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rdata    = '0;
    bus.mem_rvalid   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Cold miss on 0x100
    hs0 = n_hs;
    rd(64'h100);
    serve(2, 32'hA0, -1, -1, 0);
    chk("t1_rdata", 64'(resp_q[$]), 64'hA0);
    chk("t1_maddr", last_maddr, 64'h100);
    chk("t1_hs",    64'(n_hs - hs0), 64'd1);

    // Back-to-back hits on the rest of the line
    r0 = n_resp;
    bus.ic_read_en = 1'b1;
    bus.ic_read_addr = 64'h104; tick();
    bus.ic_read_addr = 64'h108; tick();
    bus.ic_read_addr = 64'h10C; tick();
    bus.ic_read_en = 1'b0;
    tick();
    tick();
    chk("t2_count", 64'(n_resp - r0), 64'd3);
    chk("t2_w1", 64'(resp_q[$-2]), 64'hA1);
    chk("t2_w2", 64'(resp_q[$-1]), 64'hA2);
    chk("t2_w3", 64'(resp_q[$]),   64'hA3);
    chk("t2_no_refill", 64'(n_hs - hs0), 64'd1);

    // Flush in idle, then last word of a cold line with a gap between beats 1 and 2
    bus.ic_flush = 1'b1;
    tick();
    bus.ic_flush = 1'b0;
    hs0 = n_hs;
    rd(64'h10C);
    serve(3, 32'hB0, 1, -1, 1);
    chk("t3_rdata", 64'(resp_q[$]), 64'hB3);
    chk("t3_maddr", last_maddr, 64'h100);
    chk("t3_hs",    64'(n_hs - hs0), 64'd1);

    // Conflicting tags on index 0
    hs0 = n_hs;
    rd(64'h100);
    tick();
    chk("t4_hit", 64'(resp_q[$]), 64'hB0);
    rd(64'h200);
    serve(1, 32'hC0, -1, -1, 0);
    chk("t4_conflict", 64'(resp_q[$]), 64'hC0);
    rd(64'h100);
    serve(0, 32'hD0, -1, -1, 0);
    chk("t4_evicted", 64'(resp_q[$]), 64'hD0);
    chk("t4_hs", 64'(n_hs - hs0), 64'd2);

    // Flush during refill, then flush coincident with a hit
    rd(64'h300);
    serve(1, 32'hE0, -1, 1, 0);
    chk("t5_inflight", 64'(resp_q[$]), 64'hE0);
    hs0 = n_hs;
    rd(64'h300);
    serve(0, 32'hF0, -1, -1, 0);
    chk("t5_remiss", 64'(n_hs - hs0), 64'd1);
    chk("t5_rdata",  64'(resp_q[$]), 64'hF0);
    r0 = n_resp;
    bus.ic_read_en   = 1'b1;
    bus.ic_read_addr = 64'h300;
    bus.ic_flush     = 1'b1;
    tick();
    bus.ic_read_en   = 1'b0;
    bus.ic_flush     = 1'b0;
    tick();
    chk("t5_flush_hit", 64'(resp_q[$]), 64'hF0);
    chk("t5_flush_hit_cnt", 64'(n_resp - r0), 64'd1);
    hs0 = n_hs;
    rd(64'h300);
    serve(0, 32'h10, -1, -1, 0);
    chk("t5_after_flush", 64'(n_hs - hs0), 64'd1);
    chk("t5_after_rdata", 64'(resp_q[$]), 64'h10);

    // Reset in the middle of a refill
    r0 = n_resp;
    rd(64'h400);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h20; tick();
    bus.mem_rdata  = 32'h21; tick();
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_mem_req", 64'(bus.mem_req),   64'd0);
    chk("t6_rvalid",  64'(bus.ic_rvalid), 64'd0);
    chk("t6_no_resp", 64'(n_resp - r0),   64'd0);
    hs0 = n_hs;
    rd(64'h400);
    serve(0, 32'h30, -1, -1, 0);
    chk("t6_remiss", 64'(n_hs - hs0), 64'd1);
    chk("t6_rdata",  64'(resp_q[$]), 64'h30);
    chk("t6_maddr",  last_maddr, 64'h400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ic_responder.md
Name: ic_responder

Overview:
- Instruction-cache responder on the fetch-side I-cache interface: accepts ic_read_en/ic_read_addr and returns ic_rdata/ic_rvalid.
- Direct-mapped, read-only cache with multi-word lines.
- On a miss it refills the whole line from a backing-memory request/response port, then returns the requested word.
- Sits between instruction fetch and the memory/bus bridge.

Parameters:
- IC_ADDR_WIDTH, 64, byte address width of fetch and memory addresses.
- IC_DATA_WIDTH, 32, instruction word width; byte offset is 2 bits.
- LINES, 16, number of cache lines; power of two.
- WORDS_PER_LINE, 4, words per line; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ic_read_addr  input  IC_ADDR_WIDTH  fetch byte address.
- ic_read_en  input  1  fetch read request, sampled only while ic_ready=1.
- ic_ready  output  1  responder can accept a request this cycle.
- ic_rdata  output  IC_DATA_WIDTH  returned instruction word.
- ic_rvalid  output  1  ic_rdata valid, single-cycle pulse per accepted request.
- ic_flush  input  1  invalidate all lines.
- mem_req  output  1  line refill request.
- mem_addr  output  IC_ADDR_WIDTH  line-aligned refill address.
- mem_gnt  input  1  memory accepts request; handshake completes when mem_req and mem_gnt are both 1.
- mem_rdata  input  IC_DATA_WIDTH  refill beat data.
- mem_rvalid  input  1  refill beat valid, beats arrive in ascending word order.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: all valid bits 0, state IDLE, ic_ready=1, ic_rvalid=0, ic_rdata=0, mem_req=0, mem_addr=0, flush_pending=0.
- Reset asserted mid-refill aborts the refill immediately. No partial line is left valid.
- Address split:
  - addr[1:0] ignored (misaligned addresses are treated as aligned).
  - word = next log2(WORDS_PER_LINE) bits.
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: per line, valid bit, tag, and WORDS_PER_LINE data words. All state is flopped; no memory macro.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
- IDLE:
  - ic_ready=1.
  - On ic_read_en, lookup the line. Hit = valid[index] and tag match.
  - On a hit, next cycle ic_rvalid=1 with the stored word; stay in IDLE.
  - Latency is 1 cycle, and back-to-back hits sustain one response per cycle.
  - On a miss, latch the address and go to MISS_REQ; ic_rvalid stays 0.
- MISS_REQ:
  - ic_ready=0, mem_req=1, mem_addr = latched address with word and byte bits zeroed.
  - mem_req and mem_addr are held stable until mem_gnt.
  - On mem_gnt, drop mem_req next cycle and go to REFILL.
- REFILL:
  - ic_ready=0.
  - Beat counter starts at 0. Each mem_rvalid writes mem_rdata to word[counter] and increments the counter.
  - mem_rvalid arriving in the same cycle as mem_gnt is not legal; memory returns beats starting the cycle after grant or later.
  - Gaps between beats are allowed.
  - On the final beat (counter = WORDS_PER_LINE-1), set valid and tag and go to RESP.
- RESP:
  - ic_rvalid=1 with the requested word from the latched address, taken from the refilled line. This is a combined path, so the response is correct even when the requested word was the last beat.
  - ic_ready=0 for this cycle, then IDLE.
  - Miss latency = grant wait + beats + 2 cycles.
- Flush:
  - In IDLE, ic_flush clears all valid bits at the clock edge.
  - A lookup in the same cycle is evaluated against pre-flush state: a hit still returns data.
  - If ic_flush is asserted in a non-IDLE state, set flush_pending. Valid bits, including the line just refilled, are cleared on the RESP->IDLE edge. The in-flight response is still delivered.
- Requests with ic_ready=0: ic_read_en is ignored and the fetch must re-present the request. No queueing.
- Each accepted request produces exactly one ic_rvalid pulse, in request order.
- Tag compare uses the full tag width.
- Index wrap: a conflicting address with the same index and a different tag misses and overwrites the line.

Test Plan:
- Reset, then read 0x100 -> ic_ready=1, ic_rvalid=0. A miss issues mem_req with mem_addr=0x100. Grant after 2 cycles, beats 0xA0..0xA3 -> ic_rvalid with ic_rdata=0xA0 in the cycle after the last beat.
- After the refill, reads at 0x104, 0x108, 0x10C on consecutive cycles -> ic_rvalid on 3 consecutive cycles with 0xA1, 0xA2, 0xA3, no mem_req.
- Read 0x10C on a cold cache, beats 0xB0..0xB3 with a 1-cycle gap between beats 1 and 2 -> ic_rdata=0xB3, and mem_addr=0x100 held until grant.
- Conflict: 0x100 then 0x200 (LINES=16, 16-byte lines, so same index) -> second access misses and refills. A subsequent read of 0x100 misses again.
- ic_flush asserted during REFILL -> the current response is still delivered. A re-read of the same address afterwards misses. A flush in IDLE coincident with a hit still returns the data.
- Assert rst_n=0 mid-REFILL, then release -> mem_req=0, ic_rvalid=0, and a re-read of the same address misses.
